// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
package rr_mux_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req starting at ptr.
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = ptr;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                winner = idx_to_onehot(cand);
                idx    = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with hold limit and registered data mux.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic [W-1:0]     y,
    output logic             y_valid
);

    localparam logic [HOLD_W-1:0] MaxHold = HOLD_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [W-1:0]      y_q;
    logic              y_valid_q;

    logic [IDX_W-1:0]  pick_ptr;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              owner_req;
    logic              others_req;
    logic              xfer;
    logic [W-1:0]      mux_data;

    // While owning, the search starts just after the owner so it is found last.
    assign pick_ptr   = (state_q == StOwn) ? sel_q + IDX_W'(1) : ptr_q;
    assign owner_req  = req[sel_q];
    assign others_req = |(req & ~gnt_q);
    assign xfer       = |(gnt_q & req);

    rr_pick u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Next-state: grant, keep, hand over or release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StOwn;
                    gnt_d   = pick_onehot;
                    sel_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            StOwn: begin
                if (owner_req && (hold_q < MaxHold || !others_req)) begin
                    if (hold_q < MaxHold) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    ptr_d = sel_q + IDX_W'(1);
                    if (pick_found) begin
                        gnt_d  = pick_onehot;
                        sel_d  = pick_idx;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Data select driven by the registered owner index.
    always_comb begin
        mux_data = a;
        unique case (sel_q)
            2'd0:    mux_data = a;
            2'd1:    mux_data = b;
            2'd2:    mux_data = c;
            2'd3:    mux_data = d;
            default: mux_data = a;
        endcase
    end

    // Capture owner data on each granted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= xfer;
            if (xfer) begin
                y_q <= mux_data;
            end
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random traffic.
module tb_rr_mux_arbiter;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned W        = 4;
    localparam int          BOUND    = 3 * MAX_HOLD + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         y_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_owner;
    int           m_hold;
    int           m_ptr;
    int           m_sel;
    logic [W-1:0] m_y;
    logic         m_yv;
    int           m_wait [4];

    rr_mux_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .W        (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_y     = '0;
        m_yv    = 1'b0;
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_yv", 32'(y_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock with the currently driven inputs; model advances alongside.
    task automatic step();
        logic [W-1:0] data [4];
        logic [3:0]   own_mask;
        logic [3:0]   others;
        logic [3:0]   exp_gnt;
        int           n_owner, n_hold, n_ptr, n_sel;
        logic [W-1:0] n_y;
        logic         n_yv;
        int           enc;

        data[0] = a; data[1] = b; data[2] = c; data[3] = d;
        n_owner = m_owner; n_hold = m_hold; n_ptr = m_ptr; n_sel = m_sel;
        n_y = m_y; n_yv = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (req[i] && m_owner != i) m_wait[i]++;
            else m_wait[i] = 0;
            chk($sformatf("starve%0d", i), 32'(m_wait[i] <= BOUND), 32'h1);
        end

        if (m_owner >= 0 && req[m_owner]) begin
            n_y  = data[m_owner];
            n_yv = 1'b1;
        end

        if (m_owner < 0) begin
            if (req != 4'b0) begin
                n_owner = first_from(m_ptr, req);
                n_hold  = 1;
                n_sel   = n_owner;
            end
        end else begin
            own_mask = 4'b0001 << m_owner;
            others   = req & ~own_mask;
            if (req[m_owner] && (m_hold < int'(MAX_HOLD) || others == 4'b0)) begin
                if (m_hold < int'(MAX_HOLD)) n_hold = m_hold + 1;
            end else begin
                n_ptr = (m_owner + 1) % 4;
                if (others != 4'b0) begin
                    n_owner = first_from(n_ptr, others);
                    n_hold  = 1;
                    n_sel   = n_owner;
                end else begin
                    n_owner = -1;
                    n_hold  = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        m_owner = n_owner; m_hold = n_hold; m_ptr = n_ptr; m_sel = n_sel;
        m_y = n_y; m_yv = n_yv;

        exp_gnt = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("y", 32'(y), 32'(m_y));
        chk("ptr", 32'(dut.ptr_q), 32'(m_ptr));
        chk("hold", 32'(dut.hold_q), 32'(m_hold));
        chk("onehot0", 32'($onehot0(gnt)), 32'h1);
        if (gnt != 4'b0) begin
            enc = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) enc = i;
            chk("sel_enc", 32'(sel), 32'(enc));
        end
    endtask

    initial begin
        int       gaps;
        int       exp_own;
        logic [3:0] r;

        req = 4'b0; a = '0; b = '0; c = '0; d = '0;
        do_reset();

        // Single requester A: grant after 1 cycle, data 1 cycle later.
        req = 4'b0001; a = 4'h5;
        step();
        chk("a_gnt", 32'(gnt), 32'h1);
        chk("a_sel", 32'(sel), 32'h0);
        chk("a_yv0", 32'(y_valid), 32'h0);
        step();
        chk("a_y", 32'(y), 32'h5);
        chk("a_yv1", 32'(y_valid), 32'h1);
        repeat (3) step();
        chk("a_cont", 32'(y_valid), 32'h1);

        // All four requesting: 4-cycle slices 0,1,2,3,0 with no gap.
        do_reset();
        req = 4'b1111; a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        gaps = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            exp_own = ((n - 1) / 4) % 4;
            chk("rr_slice", 32'(gnt), 32'(4'b0001 << exp_own));
            if (gnt == 4'b0) gaps++;
        end
        chk("rr_nogap", 32'(gaps), 32'h0);

        // Owner 2 drops in its second cycle while A waits.
        do_reset();
        req = 4'b0100;
        step();
        chk("drop_own2", 32'(gnt), 32'h4);
        req = 4'b0101;
        step();
        chk("drop_own2b", 32'(gnt), 32'h4);
        req = 4'b0001;
        step();
        chk("drop_gnt", 32'(gnt), 32'h1);
        chk("drop_ptr", 32'(dut.ptr_q), 32'h3);

        // Lone requester D holds indefinitely with continuous data.
        req = 4'b1000; d = 4'hc;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("d_gnt", 32'(gnt), 32'h8);
            if (n >= 2) chk("d_yv", 32'(y_valid), 32'h1);
        end
        chk("d_hold_sat", 32'(dut.hold_q), 32'(MAX_HOLD));

        // Reset during C ownership, then arbitration restarts from ptr 0.
        do_reset();
        req = 4'b0100;
        step();
        step();
        chk("rst_pre", 32'(gnt), 32'h4);
        do_reset();
        req = 4'b1010;
        step();
        chk("rst_post", 32'(gnt), 32'h2);

        // Random traffic; bits tend to persist so holds and hand-overs occur.
        for (int n = 0; n < 600; n++) begin
            r = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) != 0) r[i] = req[i];
            end
            req = r;
            a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
            if ($urandom_range(99) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles for one owner while another requester waits (legal range 1..15).
REQ-002 Parameter: W, default 4, data width of each requester and of the output.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  4  request per requester; bit i belongs to requester i (A=0, B=1, C=2, D=3).
REQ-006 Ports: a, b, c, d  input  W each  requester data 0..3.
REQ-007 Port: gnt  output  4  one-hot grant, registered; all zero when idle.
REQ-008 Port: sel  output  2  registered select {S1,S0} = binary index of the current owner; holds its last value when idle.
REQ-009 Port: y  output  W  registered data of the owner, captured one cycle after a granted transfer.
REQ-010 Port: y_valid  output  1  registered; high for exactly the cycles in which y carries newly captured data.

Function
REQ-011 States: IDLE (no owner) and OWN (gnt nonzero); encoding taken from the shared package.
REQ-012 Pointer ptr (2 bits) names the highest-priority requester; priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-013 IDLE with req != 0: next cycle OWN, gnt = one-hot of the first requester in pointer order, sel = its index, hold count = 1.
REQ-014 IDLE with req == 0: remain IDLE, gnt = 0.
REQ-015 A granted transfer occurs in any cycle with gnt[i]=1 and req[i]=1; on the next edge y <= data_i (selected by sel) and y_valid <= 1; otherwise y_valid <= 0 and y holds.
REQ-016 OWN, owner i, req[i]=1, hold count < MAX_HOLD or no other request: keep owner; hold count increments and saturates at MAX_HOLD.
REQ-017 OWN, owner i, req[i]=1, hold count == MAX_HOLD, another bit of req set: on the next edge, grant the next requester after i in round-robin order, with no idle bubble, and set hold count to 1.
REQ-018 OWN, owner i, req[i]=0: on the next edge, grant the next requester after i if any request is set (no bubble); otherwise go to IDLE with gnt = 0.
REQ-019 On every grant change, ptr <= (index of the old owner) + 1 mod 4; ptr is unchanged while the same owner is kept.
REQ-020 Latency: request to grant is 1 cycle; grant to y_valid is 1 cycle; no requester waits more than 3*MAX_HOLD+1 cycles while its req stays high.
REQ-021 A requester dropping req and reasserting it in the same idle period is treated as a new request; there is no stored request.
REQ-022 gnt is always zero or one-hot; sel always equals the encoded gnt whenever gnt != 0.

Reset
REQ-023 rst asserted: immediately and asynchronously, state = IDLE, gnt = 0, sel = 0, ptr = 0, hold count = 0, y = 0, y_valid = 0.
REQ-024 Reset asserted mid-ownership aborts the grant with no completing transfer; the first arbitration after release uses ptr = 0.

Structure
REQ-025 Shared package rr_mux_pkg holds the N_REQ=4 constant, the state type and encodings, and the pointer/index width.
REQ-026 One sub-module, rr_pick: purely combinational; takes req and ptr and returns a one-hot winner plus its index; it is instantiated once.
REQ-027 The W-bit 4:1 data select is inline logic driven by sel; the hold counter width is 4 bits.

Verification
REQ-028 Reset release, req=0001 held, a=4'h5 -> gnt=0001 after 1 cycle, sel=0, y=4'h5 with y_valid=1 one cycle later, continuing.
REQ-029 req=1111 held for 20 cycles, MAX_HOLD=4 -> owners 0,1,2,3,0 each for exactly 4 cycles, no gap in gnt.
REQ-030 Owner 2 drops req at its 2nd cycle while req[0]=1 -> next cycle gnt=0001, ptr=3.
REQ-031 Only req[3] for 10 cycles -> gnt=1000 held throughout, hold count saturates, y_valid continuous.
REQ-032 rst pulsed while gnt=0100 -> gnt=0, y=0, y_valid=0 in the same cycle; after release with req=1010, the grant goes to requester 1.
REQ-033 All cycles: assertion that gnt is one-hot or zero, sel matches gnt, and no starvation beyond the REQ-020 bound.
